// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: FSM states, default
// geometry and the width of the byte-address word index.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   localparam int DEPTH_WORDS_DEF = 256;
   localparam int WAIT_STATES_DEF = 2;

   // addr[31:2] of a 32-bit byte address
   localparam int WORD_IDX_W = 30;

   // Index width for a store of the given depth, never narrower than one bit.
   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Unified instruction/data store: DEPTH_WORDS x 32, synchronous write,
// combinational read on the same word index.
module mem_array #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // NOTE: the array has no reset; its contents must survive rst, and clearing
   // a RAM on reset would also stop it mapping onto a memory macro.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request in IDLE, waits
// WAIT_STATES cycles, then completes it with a one-cycle resp_valid pulse.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
   parameter int WAIT_STATES = WAIT_STATES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int                    AW        = idx_w(DEPTH_WORDS);
   localparam logic [WORD_IDX_W-1:0] DEPTH_IDX = WORD_IDX_W'(DEPTH_WORDS);
   localparam logic [3:0]            CNT_LOAD  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   state_t                state, state_next;
   logic [3:0]            cnt, cnt_next;
   logic [31:0]           addr_q, wdata_q;
   logic                  we_q;
   logic [31:0]           rdata_q;
   logic                  err_q;
   logic                  accept;
   logic                  bad;
   logic                  mem_we;
   logic [31:0]           mem_rdata;
   logic [31:0]           resp_rdata_d;
   logic [WORD_IDX_W-1:0] word_idx;
   logic [AW-1:0]         mem_idx;

   assign accept   = req_valid && req_ready;
   assign word_idx = addr_q[31:2];
   assign mem_idx  = addr_q[AW+1:2];
   assign bad      = (addr_q[1:0] != 2'b00) || (word_idx >= DEPTH_IDX);

   // The write lands on the edge that ends RESP; an async reset drops the
   // state to IDLE first, so an aborted store never reaches the array.
   assign mem_we = (state == RESP) && we_q && !bad;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // NOTE: every output of this block gets a default first so that no path
   // through the case leaves a signal unassigned and infers a latch.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (WAIT_STATES == 0) begin
                  state_next = RESP;
               end else begin
                  state_next = WAIT;
                  cnt_next   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_next = RESP;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else if (accept) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         we_q    <= req_we;
      end
   end

   mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_mem_array (
      .clk   (clk),
      .we    (mem_we),
      .idx   (mem_idx),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

   // Stores and errored requests leave read data at its previous value / zero.
   assign resp_rdata_d = bad ? 32'h0 : (we_q ? rdata_q : mem_rdata);

   // Live value during RESP, registered copy held until the next response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (state == RESP) begin
         rdata_q <= resp_rdata_d;
         err_q   <= bad;
      end
   end

   assign resp_rdata = (state == RESP) ? resp_rdata_d : rdata_q;
   assign resp_err   = (state == RESP) ? bad : err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with WAIT_STATES=2 and one
// with WAIT_STATES=0, driven from hand-computed request/response vectors.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;

   logic        req_valid0 = 1'b0, req_we0 = 1'b0;
   logic [31:0] req_addr0 = '0, req_wdata0 = '0;
   logic        req_ready0, resp_valid0, resp_err0;
   logic [31:0] resp_rdata0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid0),
      .req_we     (req_we0),
      .req_addr   (req_addr0),
      .req_wdata  (req_wdata0),
      .req_ready  (req_ready0),
      .resp_valid (resp_valid0),
      .resp_rdata (resp_rdata0),
      .resp_err   (resp_err0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic v, input logic we,
                        input logic [31:0] a, input logic [31:0] d);
      if (sel) begin
         req_valid0 = v; req_we0 = we; req_addr0 = a; req_wdata0 = d;
      end else begin
         req_valid  = v; req_we  = we; req_addr  = a; req_wdata  = d;
      end
   endtask

   function automatic logic rdy(input bit sel);
      return sel ? req_ready0 : req_ready;
   endfunction

   function automatic logic rv(input bit sel);
      return sel ? resp_valid0 : resp_valid;
   endfunction

   function automatic logic [31:0] rdat(input bit sel);
      return sel ? resp_rdata0 : resp_rdata;
   endfunction

   function automatic logic rerr(input bit sel);
      return sel ? resp_err0 : resp_err;
   endfunction

   // One request: check latency from acceptance, response fields, and that
   // the fields hold one cycle after the pulse while resp_valid drops.
   task automatic xact(input bit sel, input string tag, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata);
      int guard;
      int lat;
      int ws;
      ws    = sel ? 0 : 2;
      guard = 0;
      while (!rdy(sel) && guard < 20) begin
         tick();
         guard++;
      end
      check({tag, "_ready"}, 32'(rdy(sel)), 32'd1);
      drive(sel, 1'b1, we, addr, wdata);
      tick();
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
      lat = 1;
      while (!rv(sel) && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(ws + 1));
      check({tag, "_err"}, 32'(rerr(sel)), 32'(exp_err));
      check({tag, "_rdata"}, rdat(sel), exp_rdata);
      tick();
      check({tag, "_pulse_end"}, 32'(rv(sel)), 32'd0);
      check({tag, "_rdata_hold"}, rdat(sel), exp_rdata);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;

      // Reset values while rst is held.
      tick();
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", resp_rdata, 32'h0);
      check("rst_err", 32'(resp_err), 32'd0);
      check("rst_ready0", 32'(req_ready0), 32'd1);
      rst = 1'b0;
      tick();

      // Basic store/read, misaligned and out-of-range accesses.
      xact(0, "st10",    1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0);
      xact(0, "rd10",    1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
      xact(0, "rd13",    1'b0, 32'h13,  32'h0,        1'b1, 32'h0);
      xact(0, "rd10b",   1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
      xact(0, "st00",    1'b1, 32'h0,   32'h11111111, 1'b0, 32'hDEADBEEF);
      xact(0, "st400",   1'b1, 32'h400, 32'h12345678, 1'b1, 32'h0);
      xact(0, "rd00",    1'b0, 32'h0,   32'h0,        1'b0, 32'h11111111);
      xact(0, "st20",    1'b1, 32'h20,  32'hCAFEF00D, 1'b0, 32'h11111111);

      // Outputs hold across idle cycles.
      repeat (3) tick();
      check("idle_rdata_hold", resp_rdata, 32'h11111111);
      check("idle_err_hold", 32'(resp_err), 32'd0);
      check("idle_valid", 32'(resp_valid), 32'd0);

      // req_valid held high: accepts every 4 cycles, pulse on the 4th.
      drive(0, 1'b1, 1'b0, 32'h20, 32'h0);
      for (int i = 0; i < 12; i++) begin
         check($sformatf("hold_ready_%0d", i), 32'(req_ready), 32'((i % 4) == 0));
         check($sformatf("hold_valid_%0d", i), 32'(resp_valid), 32'((i % 4) == 3));
         if ((i % 4) == 3) check($sformatf("hold_rdata_%0d", i), resp_rdata, 32'hCAFEF00D);
         tick();
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Reset during WAIT aborts the store.
      check("abort_ready_pre", 32'(req_ready), 32'd1);
      drive(0, 1'b1, 1'b1, 32'h20, 32'h55AA55AA);
      tick();
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      check("abort_in_wait", 32'(req_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("abort_rst_ready", 32'(req_ready), 32'd1);
      check("abort_rst_valid", 32'(resp_valid), 32'd0);
      check("abort_rst_rdata", resp_rdata, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("abort_rel_ready", 32'(req_ready), 32'd1);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (resp_valid) seen++;
         tick();
      end
      check("abort_no_pulse", 32'(seen), 32'd0);
      xact(0, "rd20_old", 1'b0, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D);

      // Zero wait states: response next cycle, re-accept the cycle after.
      xact(1, "z_st08", 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0, 32'h0);
      xact(1, "z_rd08", 1'b0, 32'h8, 32'h0,        1'b0, 32'hA5A5A5A5);
      drive(1, 1'b1, 1'b0, 32'h8, 32'h0);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("z_hold_ready_%0d", i), 32'(req_ready0), 32'((i % 2) == 0));
         check($sformatf("z_hold_valid_%0d", i), 32'(resp_valid0), 32'((i % 2) == 1));
         tick();
      end
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
